// File: rtl/x_disp.sv
// x_disp: memory-mapped 4-digit, 7-segment display driver.
//
// Holds an 11-bit sign-magnitude value written over the controller bus,
// converts the 10-bit magnitude to decimal and time-multiplexes four
// common-anode digits. All outputs are active-low.
//
// Configuration macro:
//   XDISP_LZB_EN  - when defined, leading zeros on digits 2 and 1 are blanked.
//                   When undefined, digits 2 and 1 always show hundreds/tens.
//
// Parameters:
//   REFRESH_W  width of the free-running refresh counter (>= 4); each digit
//              is active for 2^(REFRESH_W-2) cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   sel       write strobe; data_in captured on a clock edge while high
//   data_in   [10] sign (1 = negative), [9:0] magnitude
//   data_out  [11:8] anodes (bit 8 = rightmost digit), [7:0] segments
//             {dp,g,f,e,d,c,b,a}; all active-low
module x_disp #(
  parameter int REFRESH_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [10:0] data_in,
  output logic [11:0] data_out
);

`ifdef XDISP_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

  // Decimal digit to active-low segment pattern, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [10:0]          value_reg;
  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           k;
  logic [9:0]           m;
  logic                 sign;
  logic                 ovf;
  logic [3:0]           hund;
  logic [3:0]           tens;
  logic [3:0]           units;
  logic [25:0]          dd;
  logic [7:0]           seg_k;

  assign k    = refresh_cnt[REFRESH_W-1 -: 2];
  assign m    = value_reg[9:0];
  assign sign = value_reg[10];
  assign ovf  = (m >= 10'd1000);

  // Value register and refresh counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg   <= '0;
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + {{(REFRESH_W-1){1'b0}}, 1'b1};
      if (sel) begin
        value_reg <= data_in;
      end
    end
  end

  // Double-dabble: BCD field lives in dd[25:10] (thousands..units), the
  // binary magnitude is shifted out of dd[9:0]. Adjust-then-shift per bit.
  always_comb begin
    dd = {16'd0, m};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (dd[4*j+10 +: 4] >= 4'd5) begin
          dd[4*j+10 +: 4] = dd[4*j+10 +: 4] + 4'd3;
        end
      end
      dd = dd << 1;
    end
    units = dd[13:10];
    tens  = dd[17:14];
    hund  = dd[21:18];
  end

  // Segment pattern for the currently scanned digit. Overflow shows " Err"
  // regardless of sign; the minus sign is suppressed for negative zero.
  always_comb begin
    seg_k = SEG_BLANK;
    case (k)
      2'd0: seg_k = ovf ? SEG_R : seg7(units);
      2'd1: begin
        if (ovf)                    seg_k = SEG_R;
        else if (LZB_EN && m < 10)  seg_k = SEG_BLANK;
        else                        seg_k = seg7(tens);
      end
      2'd2: begin
        if (ovf)                    seg_k = SEG_E;
        else if (LZB_EN && m < 100) seg_k = SEG_BLANK;
        else                        seg_k = seg7(hund);
      end
      default: seg_k = (!ovf && sign && (m != 10'd0)) ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Output register: anode/segment word for the pre-increment digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= 12'hFFF;
    end else begin
      data_out <= {~(4'b0001 << k), seg_k};
    end
  end

endmodule

// File: tb/tb_x_disp.sv
// tb_x_disp: scoreboard bench for x_disp with REFRESH_W = 4.
// A reference process pushes the expected output word on every clock edge;
// an independent monitor pops and compares after each edge. Directed writes
// cover the documented display cases, followed by randomized writes.
module tb_x_disp;

  localparam int RW = 4;

`ifdef XDISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sel;
  logic [10:0] data_in;
  logic [11:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];

  logic [7:0] dig_code [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] an_code  [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};

  x_disp #(.REFRESH_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display word for a held value and a digit position.
  function automatic logic [11:0] ref_word(input logic [10:0] v, input int k);
    int         mag;
    logic [7:0] s [0:3];
    mag = int'(v[9:0]);
    if (mag >= 1000) begin
      s[0] = 8'hAF; s[1] = 8'hAF; s[2] = 8'h86; s[3] = 8'hFF;
    end else begin
      s[0] = dig_code[mag % 10];
      s[1] = (LZB && mag < 10)  ? 8'hFF : dig_code[(mag / 10) % 10];
      s[2] = (LZB && mag < 100) ? 8'hFF : dig_code[mag / 100];
      s[3] = (v[10] && mag != 0) ? 8'hBF : 8'hFF;
    end
    return {an_code[k], s[k]};
  endfunction

  // Reference model: value and scan position as plain integers.
  logic [10:0] mv;
  int          mc;
  initial begin
    mv = '0;
    mc = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mv = '0;
        mc = 0;
        exp_q.delete();
      end else begin
        exp_q.push_back(ref_word(mv, (mc / 4) % 4));
        mc = (mc + 1) % 16;
        if (sel) mv = data_in;
      end
    end
  end

  // Monitor
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        n_cmp++;
        if (data_out !== 12'hFFF) begin
          n_bad++;
          $display("FAIL reset_out: got %03h expected FFF at %0t", data_out, $time);
        end
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got %03h expected <queued word> at %0t", data_out, $time);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL scan_word: got %03h expected %03h at %0t", data_out, e, $time);
        end
      end
    end
  end

  task automatic write_val(input logic [10:0] v, input int hold);
    @(negedge clk);
    sel     = 1'b1;
    data_in = v;
    @(negedge clk);
    sel = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  // Bounded search for a specific scanned word within a full scan period.
  task automatic expect_seen(input string name, input logic [11:0] w);
    bit found;
    found = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #2;
      if (data_out === w) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: last %03h, required word %03h not seen", name, data_out, w);
    end
  endtask

  initial begin
    logic [10:0] v;
    rst     = 1'b0;
    sel     = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (data_out !== 12'hFFF) begin
      n_bad++;
      $display("FAIL reset_hold: got %03h expected FFF", data_out);
    end
    @(negedge clk);
    rst = 1'b1;

    expect_seen("idle_d0", 12'hEC0);
    expect_seen("idle_d1", LZB ? 12'hDFF : 12'hDC0);
    expect_seen("idle_d3", 12'h7FF);

    write_val(11'h07B, 0);
    expect_seen("p123_d0", 12'hEB0);
    expect_seen("p123_d1", 12'hDA4);
    expect_seen("p123_d2", 12'hBF9);
    expect_seen("p123_d3", 12'h7FF);

    write_val(11'h42A, 0);
    expect_seen("n42_d0", 12'hEA4);
    expect_seen("n42_d1", 12'hD99);
    expect_seen("n42_d2", LZB ? 12'hBFF : 12'hBC0);
    expect_seen("n42_d3", 12'h7BF);

    write_val(11'h400, 0);
    expect_seen("negz_d0", 12'hEC0);
    expect_seen("negz_d1", LZB ? 12'hDFF : 12'hDC0);
    expect_seen("negz_d3", 12'h7FF);

    write_val(11'h3E8, 0);
    expect_seen("ovf_d0", 12'hEAF);
    expect_seen("ovf_d1", 12'hDAF);
    expect_seen("ovf_d2", 12'hB86);
    expect_seen("ovf_d3", 12'h7FF);

    write_val(11'h7FF, 20);
    write_val(11'h009, 20);
    write_val(11'h40A, 20);
    write_val(11'h063, 20);
    write_val(11'h464, 20);

    // Mid-scan reset while showing 123
    write_val(11'h07B, 6);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 12'hFFF) begin
      n_bad++;
      $display("FAIL reset_pulse: got %03h expected FFF", data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    expect_seen("post_rst_d0", 12'hEC0);
    expect_seen("post_rst_d3", 12'h7FF);

    // Back-to-back strobes: last captured value wins
    @(negedge clk);
    sel = 1'b1; data_in = 11'h07B;
    @(negedge clk);
    data_in = 11'h42A;
    @(negedge clk);
    data_in = 11'h3E7;
    @(negedge clk);
    sel = 1'b0;
    expect_seen("b2b_d0", 12'hE90);
    expect_seen("b2b_d1", 12'hD90);
    expect_seen("b2b_d2", 12'hB90);

    for (int i = 0; i < 40; i++) begin
      v = 11'($urandom);
      if ($urandom_range(0, 2) == 0) v[9:0] = 10'($urandom_range(0, 120));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        sel = 1'b1;
        data_in = 11'($urandom);
      end
      write_val(v, $urandom_range(0, 20));
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
